// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWaitDone,
    StHold
  } tx_state_e;

  localparam int unsigned DefNReq         = 4;
  localparam int unsigned DefStartTimeout = 16;
  localparam int unsigned DefHoldMax      = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot grant of the first set request found
// searching upward from ptr_i + 1, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  logic [IdxW-1:0] idx;
  logic            found;

  // Walk N positions starting after the pointer; first hit wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = ptr_i;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (idx == IdxW'(N - 1)) ? '0 : idx + IdxW'(1);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte requesters onto a single UART transmitter, with burst locking
// (req_last=0 keeps ownership) and a start handshake timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ         = DefNReq,
  parameter int unsigned START_TIMEOUT = DefStartTimeout,
  parameter int unsigned HOLD_MAX      = DefHoldMax
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic [N_REQ-1:0]   grant,
  output logic               err_timeout
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned StW  = $clog2(START_TIMEOUT + 1);
  localparam int unsigned HdW  = $clog2(HOLD_MAX + 1);

  tx_state_e        state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0]       data_q, data_d;
  logic             lock_q, lock_d;
  logic [IdxW-1:0]  last_grant_q, last_grant_d;
  logic [StW-1:0]   start_cnt_q, start_cnt_d;
  logic [HdW-1:0]   hold_cnt_q, hold_cnt_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] pick;
  logic [N_REQ-1:0] cap_oh;
  logic [7:0]       sel_data;
  logic             sel_last;
  logic [IdxW-1:0]  grant_idx;

  rr_arbiter #(
    .N   (N_REQ),
    .IdxW(IdxW)
  ) u_rr_arbiter (
    .req_i(req_valid),
    .ptr_i(last_grant_q),
    .gnt_o(pick)
  );

  // Capture strobe: arbitrated pick when free, owner-only while a burst is locked.
  assign cap_oh = (state_q == StIdle) ? pick :
                  (state_q == StHold) ? (req_valid & grant_q) : '0;

  // Select the captured byte/last flag and encode the current owner index.
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (cap_oh[i]) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
      if (grant_q[i]) begin
        grant_idx = IdxW'(i);
      end
    end
  end

  // Next-state logic for the arbitration/handshake FSM and its counters.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    data_d       = data_q;
    lock_d       = lock_q;
    last_grant_d = last_grant_q;
    start_cnt_d  = start_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    err_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|cap_oh) begin
          data_d      = sel_data;
          lock_d      = ~sel_last;
          grant_d     = cap_oh;
          start_cnt_d = '0;
          state_d     = StStart;
        end
      end
      StStart: begin
        if (tx_busy) begin
          start_cnt_d = '0;
          state_d     = StWaitDone;
        end else if (start_cnt_q == StW'(START_TIMEOUT - 1)) begin
          err_d       = 1'b1;
          lock_d      = 1'b0;
          grant_d     = '0;
          start_cnt_d = '0;
          state_d     = StIdle;
        end else begin
          start_cnt_d = start_cnt_q + StW'(1);
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (lock_q) begin
            hold_cnt_d = '0;
            state_d    = StHold;
          end else begin
            grant_d      = '0;
            last_grant_d = grant_idx;
            state_d      = StIdle;
          end
        end
      end
      StHold: begin
        if (|cap_oh) begin
          data_d      = sel_data;
          lock_d      = ~sel_last;
          hold_cnt_d  = '0;
          start_cnt_d = '0;
          state_d     = StStart;
        end else if (hold_cnt_q == HdW'(HOLD_MAX - 1)) begin
          grant_d      = '0;
          lock_d       = 1'b0;
          last_grant_d = grant_idx;
          hold_cnt_d   = '0;
          state_d      = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + HdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any frame without flagging a timeout.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      data_q       <= '0;
      lock_q       <= 1'b0;
      last_grant_q <= IdxW'(N_REQ - 1);
      start_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      data_q       <= data_d;
      lock_q       <= lock_d;
      last_grant_q <= last_grant_d;
      start_cnt_q  <= start_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      err_q        <= err_d;
    end
  end

  assign req_ready   = cap_oh;
  assign tx_start    = (state_q == StStart);
  assign tx_data     = data_q;
  assign grant       = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a serial transmitter model and a
// loopback receiver on the bench side.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        wb_rst_i;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [3:0]  grant;
  logic        err_timeout;

  logic        tx_en;
  logic        line;
  logic        rx_active;
  logic [7:0]  rx_q[$];

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant      (grant),
    .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter model: on tx_start, raise busy and shift 8N1 at 2 cycles/bit.
  initial begin
    logic [9:0] frame;
    tx_busy = 1'b0;
    line    = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_en && tx_start && !tx_busy) begin
        frame   = {1'b1, tx_data, 1'b0};
        tx_busy = 1'b1;
        for (int k = 0; k < 10; k++) begin
          line = frame[k];
          repeat (2) @(negedge clk);
        end
        line    = 1'b1;
        tx_busy = 1'b0;
      end
    end
  end

  // Loopback receiver: sample each bit at its centre.
  initial begin
    logic [7:0] b;
    rx_active = 1'b0;
    forever begin
      @(posedge clk);
      if (line == 1'b0) begin
        rx_active = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (2) @(posedge clk);
          b[j] = line;
        end
        rx_q.push_back(b);
        repeat (2) @(posedge clk);
        rx_active = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    logic [7:0] v;
    v = 8'hxx;
    if (i < rx_q.size()) v = rx_q[i];
    return v;
  endfunction

  // Wait for a capture pulse, then check pulse width, grant, data and tx_start.
  task automatic expect_grant(input int idx, input logic [7:0] byte_exp, input string tag);
    int         n;
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    n  = 0;
    #1;
    while (req_ready === 4'b0000 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(req_ready), 32'h0);
    chk({tag, "_grant"}, 32'(grant), 32'(oh));
    chk({tag, "_data"}, 32'(tx_data), 32'(byte_exp));
    chk({tag, "_start"}, 32'(tx_start), 32'h1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!(grant === 4'b0000 && tx_busy === 1'b0 && rx_active === 1'b0) && n < 400);
    chk({tag, "_idle"}, 32'(grant === 4'b0000 && tx_busy === 1'b0), 32'h1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int   n;
    logic err_seen;
    wb_rst_i  = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_en     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_start", 32'(tx_start), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_err", 32'(err_timeout), 32'h0);
    chk("rst_data", 32'(tx_data), 32'h0);
    wb_rst_i = 1'b0;

    // Round-robin over all four requesters.
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_last  = 4'hF;
    req_valid = 4'hF;
    expect_grant(0, 8'h10, "rr0");
    expect_grant(1, 8'h11, "rr1");
    expect_grant(2, 8'h12, "rr2");
    expect_grant(3, 8'h13, "rr3");
    expect_grant(0, 8'h10, "rr0b");
    req_valid = '0;
    wait_idle("rr");

    // Locked burst from requester 2 while requester 1 waits.
    rx_q.delete();
    req_data[23:16] = 8'h3D;
    req_last        = 4'b0010;
    req_valid       = 4'b0100;
    expect_grant(2, 8'h3D, "burst_a");
    req_data[23:16] = 8'h41;
    req_valid       = 4'b0110;
    expect_grant(2, 8'h41, "burst_b");
    req_data[23:16] = 8'h42;
    req_last[2]     = 1'b1;
    expect_grant(2, 8'h42, "burst_c");
    req_valid = 4'b0010;
    expect_grant(1, 8'h11, "burst_next");
    req_valid = '0;
    wait_idle("burst");
    chk("burst_rx_n", 32'(rx_q.size()), 32'd4);
    chk("burst_rx0", 32'(rx_at(0)), 32'h3D);
    chk("burst_rx1", 32'(rx_at(1)), 32'h41);
    chk("burst_rx2", 32'(rx_at(2)), 32'h42);

    // Start timeout with the transmitter never going busy.
    tx_en          = 1'b0;
    req_data[7:0]  = 8'h55;
    req_last       = 4'hF;
    req_valid      = 4'b0001;
    expect_grant(0, 8'h55, "to");
    req_valid = 4'b0010;
    err_seen  = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (err_timeout) err_seen = 1'b1;
    end
    chk("to_early_err", 32'(err_seen), 32'h0);
    chk("to_start_held", 32'(tx_start), 32'h1);
    @(negedge clk);
    chk("to_err", 32'(err_timeout), 32'h1);
    chk("to_grant", 32'(grant), 32'h0);
    chk("to_start_drop", 32'(tx_start), 32'h0);
    chk("to_next_ready", 32'(req_ready), 32'h2);
    tx_en = 1'b1;
    @(negedge clk);
    chk("to_err_pulse", 32'(err_timeout), 32'h0);
    chk("to_next_grant", 32'(grant), 32'h2);
    req_valid = '0;
    wait_idle("to");

    // Lock released after 64 idle cycles; pending requester 3 then wins.
    req_data[23:16] = 8'h77;
    req_data[31:24] = 8'hA5;
    req_last        = 4'b1011;
    req_valid       = 4'b0100;
    expect_grant(2, 8'h77, "hold");
    req_valid = 4'b1000;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (tx_busy !== 1'b1 && n < 100);
    do begin
      @(posedge clk);
      n++;
    end while (tx_busy !== 1'b0 && n < 200);
    chk("hold_frame_end", 32'(tx_busy), 32'h0);
    @(negedge clk);
    repeat (63) @(negedge clk);
    chk("hold_still_grant", 32'(grant), 32'h4);
    chk("hold_ignore_other", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("hold_release_grant", 32'(grant), 32'h0);
    chk("hold_release_ready", 32'(req_ready), 32'h8);
    @(negedge clk);
    chk("hold_next_grant", 32'(grant), 32'h8);
    req_valid = '0;
    wait_idle("hold");

    // Reset during WAIT_DONE.
    req_last       = 4'hF;
    req_data[15:8] = 8'h22;
    req_valid      = 4'b0010;
    expect_grant(1, 8'h22, "rst");
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (tx_busy !== 1'b1 && n < 100);
    @(negedge clk);
    wb_rst_i  = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("rst_mid_grant", 32'(grant), 32'h0);
    chk("rst_mid_start", 32'(tx_start), 32'h0);
    chk("rst_mid_err", 32'(err_timeout), 32'h0);
    chk("rst_mid_data", 32'(tx_data), 32'h0);
    wb_rst_i      = 1'b0;
    req_data[7:0] = 8'h66;
    req_valid     = 4'b1001;
    expect_grant(0, 8'h66, "rst_first");
    req_valid = '0;
    wait_idle("rst");

    // Loopback of byte 61 from requester 3.
    rx_q.delete();
    req_data[31:24] = 8'd61;
    req_last        = 4'hF;
    req_valid       = 4'b1000;
    expect_grant(3, 8'h3D, "loop");
    req_valid = '0;
    wait_idle("loop");
    chk("loop_rx_n", 32'(rx_q.size()), 32'd1);
    chk("loop_rx_byte", 32'(rx_at(0)), 32'h3D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
